fp_result_packer: RTL and testbench
===================================

Name: fp_result_packer

Overview:
- Output end of the single-precision FP datapath; the inverse of the operand classifier.
- Takes an unpacked result (sign, biased exponent, significand with guard/round/sticky bits) plus special-case flags from the arithmetic core.
- Rounds to nearest even, resolves overflow and underflow, and packs an IEEE-754 binary32 word with status flags.
- Two-stage pipeline with valid/ready handshake on both sides.

Parameters:
- EXP_W, 10, width of the signed biased exponent input (two's complement; values may be <=0 or >=255).
- QNAN, 32'h7FC00000, canonical NaN emitted for any NaN result.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  packer accepts a beat this cycle
- in_sign  in  1  result sign
- in_exp  in  EXP_W  signed biased exponent of the significand in in_mant
- in_mant  in  27  [26] hidden bit (must be 1 for normal inputs), [25:3] fraction, [2] guard, [1] round, [0] sticky
- in_zero  in  1  result is exact zero
- in_inf  in  1  result is infinity
- in_nan  in  1  result is NaN / invalid operation
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts
- out_result  out  32  packed binary32
- out_overflow  out  1  finite result rounded to infinity
- out_underflow  out  1  nonzero result flushed to zero
- out_inexact  out  1  rounding or flush lost information
- out_invalid  out  1  NaN emitted

Behaviour:
- Reset: all outputs 0 (out_valid=0, out_result=0, all flags 0), both pipeline stages empty. Reset mid-operation discards in-flight beats with no output.
- Handshake:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - in_ready = !(s2_valid && !out_ready), combinational.
  - Stall freezes both stages. While out_valid && !out_ready, out_result and all flags stay stable.
- Latency: exactly 2 cycles from input transfer to out_valid, with no stall. Throughput: 1 beat per cycle.
- Flag priority: nan > inf > zero > normal. Lower flags are ignored when a higher one is set.
- Stage 1 (register):
  - Decode the class from the flags.
  - Compute lsb = in_mant[3], g = in_mant[2], rs = in_mant[1] | in_mant[0].
  - inc = g && (rs || lsb); inexact_pre = g || rs.
  - Register sign, exp, in_mant[26:3], inc, inexact_pre and class.
- Stage 2 (register):
  - sig25 = {1'b0, sig24} + inc.
  - If sig25[24] is set: frac = sig25[23:1], exp = exp + 1. Otherwise frac = sig25[22:0].
  - Then, for the normal class:
    - exp >= 255 -> {sign, 8'hFF, 23'd0}; overflow=1, inexact=1.
    - exp <= 0 -> {sign, 31'd0} (flush to zero, no denormal outputs); underflow=1, inexact=1.
    - Otherwise {sign, exp[7:0], frac}; inexact = inexact_pre.
  - nan -> QNAN, invalid=1, all other flags 0.
  - inf -> {sign, 8'hFF, 23'd0}, all flags 0.
  - zero -> {sign, 31'd0}, all flags 0.
- Width rules: exponent arithmetic is signed, EXP_W+1 bits, so the +1 carry cannot wrap. in_mant[26]=0 with the normal class is illegal; the bench must not drive it.
- Simultaneous events: an accept and a drain in the same cycle are legal; the pipeline shifts with no bubble. in_valid held while in_ready=0 must not cause a duplicate accept.

Decomposition:
- Shared package fp32_pkg: constants for bias (127), EXP_MAX (255), QNAN, field positions (sign 31, exp 30:23, frac 22:0), and a class enum {CLS_NORMAL, CLS_ZERO, CLS_INF, CLS_NAN}, reusable by the classifier.
- One natural sub-module: fp_round_rne, combinational; takes sig24, g, r, s and returns inc and inexact. Instantiated in stage 1.

Test Plan:
- exp=127, mant=27'h4000000 -> out_result=32'h3F800000 exactly 2 cycles later, all flags 0.
- Tie-to-even: exp=127, mant=27'h4000004 -> 32'h3F800000, inexact=1. mant=27'h400000C -> 32'h3F800002, inexact=1.
- Significand carry: exp=127, mant=27'h7FFFFFC -> 32'h40000000, inexact=1. Same mant with exp=254 -> 32'h7F800000, overflow=1, inexact=1.
- Specials:
  - in_nan=1 with in_inf=1 -> 32'h7FC00000, invalid=1.
  - in_inf=1, sign=1 -> 32'hFF800000.
  - in_zero=1, sign=1 -> 32'h80000000.
  - exp=0, mant=27'h4000000 -> 32'h00000000, underflow=1.
- Backpressure: stream 4 back-to-back beats; hold out_ready=0 for 3 cycles after the first out_valid. in_ready drops, out_result stays stable, and all 4 results arrive in order with none lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight -> out_valid=0 the next cycle, and no stale result appears afterwards.

Source files
------------

// File: rtl/fp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp32_pkg
//  Purpose  : Shared binary32 constants, field positions and result classes
//             for the single-precision FP datapath (classifier and packer).
//  Revision : 1.0  initial release
// ============================================================================
package fp32_pkg;

    localparam int          c_BIAS      = 127;
    localparam int          c_EXP_MAX   = 255;
    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;

    // binary32 field positions
    localparam int          c_SIGN_POS  = 31;
    localparam int          c_EXP_MSB   = 30;
    localparam int          c_EXP_LSB   = 23;
    localparam int          c_FRAC_MSB  = 22;
    localparam int          c_FRAC_LSB  = 0;

    typedef enum logic [1:0] {
        CLS_NORMAL = 2'd0,
        CLS_ZERO   = 2'd1,
        CLS_INF    = 2'd2,
        CLS_NAN    = 2'd3
    } fp_class_e;

    // Priority decode of the special-case flags: nan > inf > zero > normal
    function automatic fp_class_e fp_decode_class(input logic nan,
                                                  input logic inf,
                                                  input logic zero);
        fp_class_e cls;
        if (nan)       cls = CLS_NAN;
        else if (inf)  cls = CLS_INF;
        else if (zero) cls = CLS_ZERO;
        else           cls = CLS_NORMAL;
        return cls;
    endfunction

endpackage : fp32_pkg
`default_nettype wire

// File: rtl/fp_round_rne.sv
`default_nettype none
// ============================================================================
//  Module   : fp_round_rne
//  Purpose  : Round-to-nearest-even decision for a 24-bit significand with
//             guard / round / sticky bits. Purely combinational.
//  Revision : 1.0  initial release
// ============================================================================
module fp_round_rne
    import fp32_pkg::*;
(
    input  logic [23:0] i_sig24,
    input  logic        i_g,
    input  logic        i_r,
    input  logic        i_s,
    output logic        o_inc,
    output logic        o_inexact
);

    logic w_lsb;
    logic w_rs;
    logic w_unused_sig;

    // Only the significand LSB matters for breaking a tie
    assign w_unused_sig = ^i_sig24[23:1];

    // Round up above half, or at exactly half when the LSB is odd
    always_comb begin
        w_lsb     = i_sig24[0];
        w_rs      = i_r | i_s;
        o_inc     = i_g & (w_rs | w_lsb);
        o_inexact = i_g | w_rs;
    end

endmodule : fp_round_rne
`default_nettype wire

// File: rtl/fp_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fp_result_packer
//  Purpose  : Output end of the binary32 datapath. Rounds an unpacked result
//             (RNE), resolves overflow / flush-to-zero underflow, and packs an
//             IEEE-754 word with status flags. Two-stage valid/ready pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module fp_result_packer
    import fp32_pkg::*;
#(
    parameter int          EXP_W = 10,
    parameter logic [31:0] QNAN  = c_QNAN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [26:0]      in_mant,
    input  logic             in_zero,
    input  logic             in_inf,
    input  logic             in_nan,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_overflow,
    output logic             out_underflow,
    output logic             out_inexact,
    output logic             out_invalid
);

    // Exponent arithmetic is one bit wider than the input so +1 cannot wrap
    localparam logic signed [EXP_W:0] c_EXP_ONE  = (EXP_W+1)'(1);
    localparam logic signed [EXP_W:0] c_EXP_ZERO = (EXP_W+1)'(0);
    localparam logic signed [EXP_W:0] c_EXP_TOP  = (EXP_W+1)'(c_EXP_MAX);

    // ---------------- stage 1 state ----------------
    logic             r_s1_valid_q,   w_s1_valid_d;
    logic             r_s1_sign_q,    w_s1_sign_d;
    logic [EXP_W-1:0] r_s1_exp_q,     w_s1_exp_d;
    logic [23:0]      r_s1_sig24_q,   w_s1_sig24_d;
    logic             r_s1_inc_q,     w_s1_inc_d;
    logic             r_s1_inex_q,    w_s1_inex_d;
    fp_class_e        r_s1_cls_q,     w_s1_cls_d;

    // ---------------- stage 2 state ----------------
    logic             r_s2_valid_q,   w_s2_valid_d;
    logic [31:0]      r_result_q,     w_result_d;
    logic             r_ovf_q,        w_ovf_d;
    logic             r_unf_q,        w_unf_d;
    logic             r_inex_q,       w_inex_d;
    logic             r_inv_q,        w_inv_d;

    logic             w_stall;
    logic             w_rnd_inc;
    logic             w_rnd_inexact;

    logic [24:0]      w_sig25;
    logic [22:0]      w_frac;
    logic signed [EXP_W:0] w_exp_ext;
    logic signed [EXP_W:0] w_exp_adj;
    logic [31:0]      w_pk_result;
    logic             w_pk_ovf;
    logic             w_pk_unf;
    logic             w_pk_inex;
    logic             w_pk_inv;

    // A full output register that is not being drained freezes the pipe
    assign w_stall  = r_s2_valid_q & ~out_ready;
    assign in_ready = ~w_stall;

    fp_round_rne u_round (
        .i_sig24   (in_mant[26:3]),
        .i_g       (in_mant[2]),
        .i_r       (in_mant[1]),
        .i_s       (in_mant[0]),
        .o_inc     (w_rnd_inc),
        .o_inexact (w_rnd_inexact)
    );

    // Stage 1 next state: capture the beat and its rounding decision unless stalled
    always_comb begin
        w_s1_valid_d = r_s1_valid_q;
        w_s1_sign_d  = r_s1_sign_q;
        w_s1_exp_d   = r_s1_exp_q;
        w_s1_sig24_d = r_s1_sig24_q;
        w_s1_inc_d   = r_s1_inc_q;
        w_s1_inex_d  = r_s1_inex_q;
        w_s1_cls_d   = r_s1_cls_q;
        if (!w_stall) begin
            w_s1_valid_d = in_valid;
            w_s1_sign_d  = in_sign;
            w_s1_exp_d   = in_exp;
            w_s1_sig24_d = in_mant[26:3];
            w_s1_inc_d   = w_rnd_inc;
            w_s1_inex_d  = w_rnd_inexact;
            w_s1_cls_d   = fp_decode_class(in_nan, in_inf, in_zero);
        end
    end

    // Apply the increment, renormalise on carry-out, then pack by class
    always_comb begin
        w_sig25   = {1'b0, r_s1_sig24_q} + {24'd0, r_s1_inc_q};
        w_exp_ext = {r_s1_exp_q[EXP_W-1], r_s1_exp_q};
        if (w_sig25[24]) begin
            w_frac    = w_sig25[23:1];
            w_exp_adj = w_exp_ext + c_EXP_ONE;
        end else begin
            w_frac    = w_sig25[22:0];
            w_exp_adj = w_exp_ext;
        end

        w_pk_result = 32'd0;
        w_pk_ovf    = 1'b0;
        w_pk_unf    = 1'b0;
        w_pk_inex   = 1'b0;
        w_pk_inv    = 1'b0;
        case (r_s1_cls_q)
            CLS_NAN: begin
                w_pk_result = QNAN;
                w_pk_inv    = 1'b1;
            end
            CLS_INF: begin
                w_pk_result = {r_s1_sign_q, 8'hFF, 23'd0};
            end
            CLS_ZERO: begin
                w_pk_result = {r_s1_sign_q, 31'd0};
            end
            default: begin
                if (w_exp_adj >= c_EXP_TOP) begin
                    w_pk_result = {r_s1_sign_q, 8'hFF, 23'd0};
                    w_pk_ovf    = 1'b1;
                    w_pk_inex   = 1'b1;
                end else if (w_exp_adj <= c_EXP_ZERO) begin
                    // No denormal outputs: anything below the normal range flushes
                    w_pk_result = {r_s1_sign_q, 31'd0};
                    w_pk_unf    = 1'b1;
                    w_pk_inex   = 1'b1;
                end else begin
                    w_pk_result = {r_s1_sign_q, w_exp_adj[7:0], w_frac};
                    w_pk_inex   = r_s1_inex_q;
                end
            end
        endcase
    end

    // Stage 2 next state: load the packed word, bubbles load zeros, hold when stalled
    always_comb begin
        w_s2_valid_d = r_s2_valid_q;
        w_result_d   = r_result_q;
        w_ovf_d      = r_ovf_q;
        w_unf_d      = r_unf_q;
        w_inex_d     = r_inex_q;
        w_inv_d      = r_inv_q;
        if (!w_stall) begin
            w_s2_valid_d = r_s1_valid_q;
            w_result_d   = r_s1_valid_q ? w_pk_result : 32'd0;
            w_ovf_d      = r_s1_valid_q & w_pk_ovf;
            w_unf_d      = r_s1_valid_q & w_pk_unf;
            w_inex_d     = r_s1_valid_q & w_pk_inex;
            w_inv_d      = r_s1_valid_q & w_pk_inv;
        end
    end

    // Pipeline registers with synchronous reset emptying both stages
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid_q <= 1'b0;
            r_s1_sign_q  <= 1'b0;
            r_s1_exp_q   <= '0;
            r_s1_sig24_q <= '0;
            r_s1_inc_q   <= 1'b0;
            r_s1_inex_q  <= 1'b0;
            r_s1_cls_q   <= CLS_NORMAL;
            r_s2_valid_q <= 1'b0;
            r_result_q   <= 32'd0;
            r_ovf_q      <= 1'b0;
            r_unf_q      <= 1'b0;
            r_inex_q     <= 1'b0;
            r_inv_q      <= 1'b0;
        end else begin
            r_s1_valid_q <= w_s1_valid_d;
            r_s1_sign_q  <= w_s1_sign_d;
            r_s1_exp_q   <= w_s1_exp_d;
            r_s1_sig24_q <= w_s1_sig24_d;
            r_s1_inc_q   <= w_s1_inc_d;
            r_s1_inex_q  <= w_s1_inex_d;
            r_s1_cls_q   <= w_s1_cls_d;
            r_s2_valid_q <= w_s2_valid_d;
            r_result_q   <= w_result_d;
            r_ovf_q      <= w_ovf_d;
            r_unf_q      <= w_unf_d;
            r_inex_q     <= w_inex_d;
            r_inv_q      <= w_inv_d;
        end
    end

    assign out_valid     = r_s2_valid_q;
    assign out_result    = r_result_q;
    assign out_overflow  = r_ovf_q;
    assign out_underflow = r_unf_q;
    assign out_inexact   = r_inex_q;
    assign out_invalid   = r_inv_q;

endmodule : fp_result_packer
`default_nettype wire

// File: tb/tb_fp_result_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_result_packer
//  Purpose  : Directed self-checking bench for fp_result_packer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_result_packer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [26:0] in_mant;
    logic        in_zero;
    logic        in_inf;
    logic        in_nan;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_inexact;
    logic        out_invalid;

    int tests = 0;
    int fails = 0;

    fp_result_packer #(
        .EXP_W (10),
        .QNAN  (32'h7FC0_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp        (in_exp),
        .in_mant       (in_mant),
        .in_zero       (in_zero),
        .in_inf        (in_inf),
        .in_nan        (in_nan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact),
        .out_invalid   (out_invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // flags packed as {overflow, underflow, inexact, invalid}
    function automatic logic [3:0] flags_now();
        return {out_overflow, out_underflow, out_inexact, out_invalid};
    endfunction

    // One isolated beat: accepted at the next edge, result visible two edges later
    task automatic run_beat(input string tag, input logic s, input logic [9:0] e,
                            input logic [26:0] m, input logic z, input logic inf_,
                            input logic nan_, input logic [31:0] exp_res,
                            input logic [3:0] exp_flags);
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = e;
        in_mant  = m;
        in_zero  = z;
        in_inf   = inf_;
        in_nan   = nan_;
        @(negedge clk);
        in_valid = 1'b0;
        in_zero  = 1'b0;
        in_inf   = 1'b0;
        in_nan   = 1'b0;
        chk({tag, "_lat1"}, 64'(out_valid), 64'(0));
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'(1));
        chk({tag, "_res"},   64'(out_result), 64'(exp_res));
        chk({tag, "_flags"}, 64'(flags_now()), 64'(exp_flags));
    endtask

    initial begin
        logic [31:0] bp_exp [4];
        int          sent;
        int          got;
        int          stall_left;
        bit          seen_first;
        bit          rdy_checked;
        bit          held_v;
        logic [35:0] held;
        bit          stale;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = '0;
        in_mant   = '0;
        in_zero   = 1'b0;
        in_inf    = 1'b0;
        in_nan    = 1'b0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid",  64'(out_valid),   64'(0));
        chk("rst_result", 64'(out_result),  64'(0));
        chk("rst_flags",  64'(flags_now()), 64'(0));
        chk("rst_ready",  64'(in_ready),    64'(1));
        rst = 1'b0;

        // Normal rounding and packing
        run_beat("one",        1'b0, 10'd127, 27'h4000000, 0, 0, 0, 32'h3F80_0000, 4'b0000);
        run_beat("tie_even",   1'b0, 10'd127, 27'h4000004, 0, 0, 0, 32'h3F80_0000, 4'b0010);
        run_beat("tie_up",     1'b0, 10'd127, 27'h400000C, 0, 0, 0, 32'h3F80_0002, 4'b0010);
        run_beat("above_half", 1'b0, 10'd127, 27'h4000006, 0, 0, 0, 32'h3F80_0001, 4'b0010);
        run_beat("neg_norm",   1'b1, 10'd130, 27'h6000000, 0, 0, 0, 32'hC140_0000, 4'b0000);
        run_beat("max_exact",  1'b0, 10'd254, 27'h7FFFFF8, 0, 0, 0, 32'h7F7F_FFFF, 4'b0000);
        // Significand carry, overflow
        run_beat("carry",      1'b0, 10'd127, 27'h7FFFFFC, 0, 0, 0, 32'h4000_0000, 4'b0010);
        run_beat("carry_ovf",  1'b0, 10'd254, 27'h7FFFFFC, 0, 0, 0, 32'h7F80_0000, 4'b1010);
        run_beat("exp_ovf",    1'b1, 10'd300, 27'h4000000, 0, 0, 0, 32'hFF80_0000, 4'b1010);
        // Underflow flush and a carry lifting exponent 0 into range
        run_beat("unf0",       1'b0, 10'd0,   27'h4000000, 0, 0, 0, 32'h0000_0000, 4'b0110);
        run_beat("unf_neg",    1'b1, 10'h3FB, 27'h4000004, 0, 0, 0, 32'h8000_0000, 4'b0110);
        run_beat("carry_min",  1'b0, 10'd0,   27'h7FFFFFC, 0, 0, 0, 32'h0080_0000, 4'b0010);
        // Specials and flag priority
        run_beat("nan_inf",    1'b1, 10'd127, 27'h5555555, 0, 1, 1, 32'h7FC0_0000, 4'b0001);
        run_beat("inf_neg",    1'b1, 10'd3,   27'h4000000, 0, 1, 0, 32'hFF80_0000, 4'b0000);
        run_beat("inf_zero",   1'b0, 10'd0,   27'h0000000, 1, 1, 0, 32'h7F80_0000, 4'b0000);
        run_beat("zero_neg",   1'b1, 10'd127, 27'h400000C, 1, 0, 0, 32'h8000_0000, 4'b0000);

        // Backpressure: 4 back-to-back beats, 3-cycle stall at first output
        bp_exp[0]   = 32'h3F80_0000;
        bp_exp[1]   = 32'h4000_0000;
        bp_exp[2]   = 32'h4080_0000;
        bp_exp[3]   = 32'h4100_0000;
        sent        = 0;
        got         = 0;
        stall_left  = 0;
        seen_first  = 1'b0;
        rdy_checked = 1'b0;
        held_v      = 1'b0;
        held        = '0;
        in_sign     = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (held_v) begin
                chk("bp_hold_valid", 64'(out_valid), 64'(1));
                chk("bp_hold_data", 64'({out_result, flags_now()}), 64'(held));
            end
            if (out_valid && !seen_first) begin
                seen_first = 1'b1;
                stall_left = 3;
            end
            if (stall_left > 0) begin
                out_ready  = 1'b0;
                stall_left = stall_left - 1;
            end else begin
                out_ready = 1'b1;
            end
            if (sent < 4) begin
                in_valid = 1'b1;
                in_exp   = 10'(127 + sent);
                in_mant  = 27'h4000000;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (!out_ready && !rdy_checked) begin
                rdy_checked = 1'b1;
                chk("bp_in_ready_low", 64'(in_ready), 64'(0));
            end
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 4) chk($sformatf("bp_res%0d", got), 64'(out_result), 64'(bp_exp[got]));
                got++;
            end
            held_v = out_valid && !out_ready;
            held   = {out_result, flags_now()};
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", 64'(got), 64'(4));
        chk("bp_stalled", 64'(rdy_checked), 64'(1));

        // Reset with two beats in flight
        @(negedge clk);
        in_valid = 1'b1;
        in_exp   = 10'd127;
        in_mant  = 27'h4000000;
        @(negedge clk);
        in_exp   = 10'd128;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk("mrst_valid",  64'(out_valid),   64'(0));
        chk("mrst_result", 64'(out_result),  64'(0));
        chk("mrst_flags",  64'(flags_now()), 64'(0));
        stale = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        chk("mrst_no_stale", 64'(stale), 64'(0));

        // Recovery after reset
        run_beat("post_rst", 1'b0, 10'd128, 27'h4000000, 0, 0, 0, 32'h4000_0000, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_fp_result_packer
`default_nettype wire
